// File: rtl/game_input_pkg.sv
// rtl/game_input_pkg.sv - shared types and constants for the keycode injector
package game_input_pkg;

   localparam logic [7:0] KEY_NONE   = 8'h00;
   localparam int         INJ_HOLD_W = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      PRESS   = 2'd2,
      RELEASE = 2'd3
   } inj_state_t;

   // Default-width injection request; the top re-declares it for its own HOLD_W.
   typedef struct packed {
      logic [7:0]            key;
      logic [INJ_HOLD_W-1:0] hold;
   } inj_req_t;

endpackage

// File: rtl/keycode_inject_fifo.sv
// rtl/keycode_inject_fifo.sv - synchronous request FIFO with flush, full/empty/count
module keycode_inject_fifo
   import game_input_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = inj_req_t
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   push,
   input  T                       wr_data,
   input  logic                   pop,
   input  logic                   flush,
   output T                       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   T               r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           w_do_push;
   logic           w_do_pop;

   // Full is taken from the registered count, so a pop in the same cycle never frees a slot early.
   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign rd_data   = r_mem[r_rd_ptr];
   assign w_do_push = push && !full && !flush;
   assign w_do_pop  = pop && !empty && !flush;

   // Pointer and occupancy update; flush discards everything.
   always_ff @(posedge Clk) begin
      if (Reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
         else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
      end
   end

   // Storage write; contents need no reset because count gates every read.
   always_ff @(posedge Clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/keycode_injector.sv
// rtl/keycode_injector.sv - merges scripted press/hold/release events into the live keycode bus
module keycode_injector
   import game_input_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int HOLD_W     = INJ_HOLD_W,
   parameter int GAP_FRAMES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_tick,
   input  logic [15:0]       live_keycode,
   input  logic              inject_valid,
   input  logic [7:0]        inject_key,
   input  logic [HOLD_W-1:0] inject_hold,
   output logic              inject_ready,
   input  logic              abort,
   output logic [15:0]       keycode,
   output logic              busy
);

   localparam int GAP_W = $clog2(GAP_FRAMES + 1);
   localparam int CNT_W = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
   localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_FRAMES);
   localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

   typedef struct packed {
      logic [7:0]        key;
      logic [HOLD_W-1:0] hold;
   } req_t;

   inj_state_t            r_state;
   inj_state_t            w_state_nxt;
   logic [7:0]            r_cur_key;
   logic [7:0]            w_key_nxt;
   logic [CNT_W-1:0]      r_frame_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic [15:0]           r_keycode;
   logic [15:0]           w_merged;
   req_t                  w_wr_req;
   req_t                  w_head;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [$clog2(DEPTH):0] w_count;

   assign w_wr_req     = {inject_key, inject_hold};
   assign inject_ready = !w_full;
   assign keycode      = r_keycode;
   assign busy         = (r_state != IDLE) || (w_count != '0);

   keycode_inject_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .Clk     (Clk),
      .Reset   (Reset),
      .push    (inject_valid),
      .wr_data (w_wr_req),
      .pop     (w_pop),
      .flush   (abort),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty),
      .count   (w_count)
   );

   // State, current key and frame counter registers.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= IDLE;
         r_cur_key   <= KEY_NONE;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur_key   <= w_key_nxt;
         r_frame_cnt <= w_cnt_nxt;
      end
   end

   // Event sequencing: the head is captured on the popping edge so LOAD holds it stable
   // for one cycle (ticks there are ignored) before PRESS starts counting frames.
   always_comb begin
      w_state_nxt = r_state;
      w_key_nxt   = r_cur_key;
      w_cnt_nxt   = r_frame_cnt;
      w_pop       = 1'b0;
      if (abort) begin
         if (r_state != IDLE) begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = GAP_CNT;
         end
      end else begin
         unique case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = LOAD;
                  w_key_nxt   = w_head.key;
                  w_cnt_nxt   = (w_head.hold == '0) ? ONE_CNT : CNT_W'(w_head.hold);
               end
            end
            LOAD: begin
               w_state_nxt = PRESS;
            end
            PRESS: begin
               if (frame_tick) begin
                  if (r_frame_cnt == ONE_CNT) begin
                     w_state_nxt = RELEASE;
                     w_cnt_nxt   = GAP_CNT;
                  end else begin
                     w_cnt_nxt = r_frame_cnt - ONE_CNT;
                  end
               end
            end
            RELEASE: begin
               if (frame_tick) begin
                  if (r_frame_cnt == ONE_CNT) w_state_nxt = IDLE;
                  else                        w_cnt_nxt   = r_frame_cnt - ONE_CNT;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Merge: injected key fills the free low slot, else the high slot (overriding if both
   // are taken); never duplicated when the keyboard already reports it.
   always_comb begin
      w_merged = live_keycode;
      if ((r_state == PRESS) && (r_cur_key != KEY_NONE) &&
          (live_keycode[7:0] != r_cur_key) && (live_keycode[15:8] != r_cur_key)) begin
         if (live_keycode[7:0] == KEY_NONE) w_merged[7:0]  = r_cur_key;
         else                               w_merged[15:8] = r_cur_key;
      end
   end

   // Registered output bus.
   always_ff @(posedge Clk) begin
      if (Reset) r_keycode <= 16'h0000;
      else       r_keycode <= w_merged;
   end

endmodule
